// File: rtl/mem_writer32.sv
// Sequential block write engine: latches a base address and word count, then
// turns each accepted producer word into one registered memory write.
module mem_writer32 #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16,
  parameter int STRIDE = 4
) (
  input  logic              clock,
  input  logic              nrst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [CNT_W-1:0]  word_count,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic [ADDR_W-1:0] waddress,
  output logic [DATA_W-1:0] Datain,
  output logic              Wr,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  words_written
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WRITE = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   cur_q, cur_d;
  logic [CNT_W-1:0]    rem_q, rem_d;
  logic [ADDR_W-1:0]   waddr_q, waddr_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                wr_q, wr_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                xfer;

  // The engine only ever accepts data while in WRITE.
  assign xfer = (state_q == S_WRITE) && in_valid;

  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    rem_d   = rem_q;
    waddr_d = waddr_q;
    data_d  = data_q;
    wr_d    = 1'b0;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          cur_d   = base_addr;
          rem_d   = word_count;
          cnt_d   = '0;
          state_d = (word_count == '0) ? S_DONE : S_WRITE;
        end
      end
      S_WRITE: begin
        if (xfer) begin
          waddr_d = cur_q;
          data_d  = in_data;
          wr_d    = 1'b1;
          cur_d   = cur_q + ADDR_W'(STRIDE);
          rem_d   = rem_q - CNT_W'(1);
          cnt_d   = cnt_q + CNT_W'(1);
          if (rem_q == CNT_W'(1)) begin
            state_d = S_DONE;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (!nrst) begin
      state_q <= S_IDLE;
      cur_q   <= '0;
      rem_q   <= '0;
      waddr_q <= '0;
      data_q  <= '0;
      wr_q    <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      rem_q   <= rem_d;
      waddr_q <= waddr_d;
      data_q  <= data_d;
      wr_q    <= wr_d;
      cnt_q   <= cnt_d;
    end
  end

  // The final write and the done pulse land in the same cycle.
  assign in_ready      = (state_q == S_WRITE);
  assign busy          = (state_q == S_WRITE);
  assign done          = (state_q == S_DONE);
  assign Wr            = wr_q;
  assign waddress      = waddr_q;
  assign Datain        = data_q;
  assign words_written = cnt_q;

endmodule

// File: tb/tb_mem_writer32.sv
// Scoreboard bench for mem_writer32: every accepted word queues its expected
// address/data, and every Wr pops and compares.
`timescale 1ns/1ps
module tb_mem_writer32;

  logic        clock = 1'b0;
  logic        nrst = 1'b0;
  logic        start = 1'b0;
  logic [31:0] base_addr = '0;
  logic [15:0] word_count = '0;
  logic        in_valid = 1'b0;
  logic [31:0] in_data = '0;
  logic        in_ready;
  logic [31:0] waddress;
  logic [31:0] Datain;
  logic        Wr;
  logic        busy;
  logic        done;
  logic [15:0] words_written;

  int n_tests = 0;
  int n_fail  = 0;

  logic [63:0] sb[$];
  logic [31:0] model_addr = '0;
  logic [15:0] blk_cnt = '0;
  int          wr_seen = 0;
  int          done_cycles = 0;

  mem_writer32 #(.ADDR_W(32), .DATA_W(32), .CNT_W(16), .STRIDE(4)) dut (
    .clock(clock), .nrst(nrst), .start(start), .base_addr(base_addr),
    .word_count(word_count), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .waddress(waddress), .Datain(Datain), .Wr(Wr),
    .busy(busy), .done(done), .words_written(words_written)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Monitor: compare writes first, then record this cycle's accepted word.
  always @(negedge clock) begin
    logic [63:0] e;
    if (Wr === 1'b1) begin
      wr_seen++;
      if (sb.size() == 0) begin
        check("wr_unexpected", 64'd1, 64'd0);
      end else begin
        e = sb.pop_front();
        check("waddress", 64'(waddress), 64'(e[63:32]));
        check("Datain", 64'(Datain), 64'(e[31:0]));
      end
    end
    if (done === 1'b1) begin
      done_cycles++;
      check("done_with_last_wr", 64'(Wr), 64'(blk_cnt != 16'd0));
    end
    if (!nrst) begin
      sb.delete();
    end else begin
      if (start && busy === 1'b0 && done === 1'b0) begin
        model_addr = base_addr;
        blk_cnt    = word_count;
      end
      if (in_valid && in_ready === 1'b1) begin
        sb.push_back({model_addr, in_data});
        model_addr = model_addr + 32'd4;
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic run_block(input logic [31:0] base, input logic [15:0] cnt,
                           input logic [5:0] pat, input bit rnd);
    int wr0, d0, sent, i, cyc;
    wr0 = wr_seen;
    d0  = done_cycles;
    start = 1'b1; base_addr = base; word_count = cnt;
    tick();
    start = 1'b0;
    check("busy_after_start", 64'(busy), 64'(cnt != 16'd0));
    sent = 0; i = 0;
    while (sent < int'(cnt) && i < 200) begin
      in_valid = pat[i % 6];
      in_data  = rnd ? $urandom() : 32'(sent * 17);
      @(negedge clock);
      if (in_valid && in_ready) sent++;
      tick();
      i++;
    end
    in_valid = 1'b0;
    if (i >= 200) check("xfer_timeout", 64'(sent), 64'(cnt));
    cyc = 0;
    while (done_cycles == d0 && cyc < 50) begin
      tick();
      cyc++;
    end
    if (cyc >= 50) check("done_timeout", 64'd0, 64'd1);
    check("idle_done_low", 64'(done), 64'd0);
    check("idle_ready_low", 64'(in_ready), 64'd0);
    check("wr_count", 64'(wr_seen - wr0), 64'(cnt));
    check("done_cycles", 64'(done_cycles - d0), 64'd1);
    check("words_written", 64'(words_written), 64'(cnt));
    check("sb_drained", 64'(sb.size()), 64'd0);
    $display("[TB] block base=0x%08h count=%0d done (last waddress=0x%08h)", base, cnt, waddress);
  endtask

  initial begin
    int w0, d0;
    // Reset
    repeat (3) tick();
    check("rst_in_ready", 64'(in_ready), 64'd0);
    check("rst_wr", 64'(Wr), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_waddress", 64'(waddress), 64'd0);
    check("rst_datain", 64'(Datain), 64'd0);
    check("rst_words", 64'(words_written), 64'd0);
    nrst = 1'b1;
    tick();

    // Valid while idle must not be consumed
    w0 = wr_seen;
    in_valid = 1'b1; in_data = 32'hDEAD_BEEF;
    repeat (3) begin
      check("idle_no_ready", 64'(in_ready), 64'd0);
      tick();
    end
    in_valid = 1'b0;
    check("idle_no_wr", 64'(wr_seen - w0), 64'd0);

    // Streaming every cycle
    run_block(32'h0000_0000, 16'd17, 6'b111111, 1'b0);
    check("hold_waddress", 64'(waddress), 64'h40);
    check("hold_datain", 64'(Datain), 64'h110);

    // Gapped valid
    run_block(32'h0000_0100, 16'd4, 6'b101101, 1'b1);
    check("gap_last_addr", 64'(waddress), 64'h10C);

    // Empty block
    run_block(32'h0000_0800, 16'd0, 6'b111111, 1'b1);

    // Address wrap
    run_block(32'hFFFF_FFF8, 16'd3, 6'b111111, 1'b1);
    check("wrap_last_addr", 64'(waddress), 64'h0);

    // Unaligned base used as-is
    run_block(32'h0000_0203, 16'd2, 6'b110111, 1'b1);

    // Reset after two of eight words
    w0 = wr_seen; d0 = done_cycles;
    start = 1'b1; base_addr = 32'h0000_0200; word_count = 16'd8;
    tick();
    start = 1'b0;
    in_valid = 1'b1; in_data = $urandom();
    tick();
    in_data = $urandom();
    tick();
    nrst = 1'b0;
    tick();
    in_valid = 1'b0;
    check("midrst_wr", 64'(Wr), 64'd0);
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_ready", 64'(in_ready), 64'd0);
    check("midrst_waddress", 64'(waddress), 64'd0);
    check("midrst_words", 64'(words_written), 64'd0);
    check("midrst_wr_count", 64'(wr_seen - w0), 64'd2);
    check("midrst_no_done", 64'(done_cycles - d0), 64'd0);
    $display("[TB] reset mid-block after %0d writes", wr_seen - w0);
    nrst = 1'b1;
    run_block(32'h0000_0040, 16'd1, 6'b111111, 1'b1);
    check("post_rst_addr", 64'(waddress), 64'h40);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
